// File: rtl/line_square_packer.sv
// Pixel-to-line packer with ping-pong banks; feeds adder_tree one LINE_SIZE line at a time.
// Optional macro PIX_SQUARE_EN: store pix_in*pix_in instead of zero-extended pix_in.
module line_square_packer #(
    parameter int PIXEL_SIZE = 8,
    parameter int LINE_SIZE  = 16
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic [PIXEL_SIZE-1:0]                    pix_in,
    input  logic                                     pix_valid,
    input  logic                                     pix_last,
    output logic                                     pix_ready,
    output logic [LINE_SIZE-1:0][2*PIXEL_SIZE-1:0]   line_out,
    output logic [$clog2(LINE_SIZE):0]               line_len,
    output logic                                     line_valid,
    input  logic                                     line_ready
);

    localparam int PW    = 2 * PIXEL_SIZE;
    localparam int IDX_W = $clog2(LINE_SIZE);
    localparam int LEN_W = IDX_W + 1;

    logic [PW-1:0]         bank [2][LINE_SIZE];
    logic [1:0][LEN_W-1:0] bank_len;
    logic [1:0]            bank_full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [IDX_W-1:0]      wr_idx;

    logic                  pix_fire;
    logic                  line_fire;
    logic                  line_end;
    logic [PW-1:0]         elem;

    assign pix_ready  = !bank_full[wr_bank];
    assign line_valid = bank_full[rd_bank];
    assign line_len   = bank_len[rd_bank];

    assign pix_fire  = pix_valid && pix_ready;
    assign line_fire = line_valid && line_ready;
    assign line_end  = (wr_idx == IDX_W'(LINE_SIZE - 1)) || pix_last;

`ifdef PIX_SQUARE_EN
    assign elem = PW'(pix_in) * PW'(pix_in);
`else
    assign elem = PW'(pix_in);
`endif

    // NOTE: sample storage has no reset; bank_full/bank_len decide what is real,
    // so a reset-free memory is both legal and cheaper to map to RAM.
    always_ff @(posedge CLK) begin
        if (pix_fire) begin
            bank[wr_bank][wr_idx] <= elem;
        end
    end

    // Completion and consumption always target different banks, so both
    // bit updates of bank_full can land on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bank_full <= '0;
            bank_len  <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
        end else begin
            if (pix_fire) begin
                if (line_end) begin
                    bank_full[wr_bank] <= 1'b1;
                    bank_len[wr_bank]  <= LEN_W'(wr_idx) + LEN_W'(1);
                    wr_bank            <= ~wr_bank;
                    wr_idx             <= '0;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (line_fire) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    // Elements past line_len read as zero so a short line sums only real pixels.
    // NOTE: default assigned first so every path drives line_out (no latch).
    always_comb begin
        line_out = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (LEN_W'(i) < line_len) begin
                line_out[i] = bank[rd_bank][i];
            end
        end
    end

endmodule

// File: tb/tb_line_square_packer.sv
// Directed self-checking bench for line_square_packer (PIX_SQUARE_EN aware).
module tb_line_square_packer;

    localparam int PS = 8;
    localparam int LS = 16;
    localparam int PW = 2 * PS;
    localparam int LW = $clog2(LS) + 1;

    logic                    CLK = 1'b0;
    logic                    RST_N;
    logic [PS-1:0]           pix_in;
    logic                    pix_valid;
    logic                    pix_last;
    logic                    pix_ready;
    logic [LS-1:0][PW-1:0]   line_out;
    logic [LW-1:0]           line_len;
    logic                    line_valid;
    logic                    line_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [LS-1:0][PW-1:0] exp_line;
    int                    exp_sum;

    always #5 CLK = ~CLK;

    line_square_packer #(.PIXEL_SIZE(PS), .LINE_SIZE(LS)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .line_out   (line_out),
        .line_len   (line_len),
        .line_valid (line_valid),
        .line_ready (line_ready)
    );

    function automatic logic [PW-1:0] elem(input int v);
`ifdef PIX_SQUARE_EN
        return PW'(v * v);
`else
        return PW'(v);
`endif
    endfunction

    function automatic int line_sum(input logic [LS-1:0][PW-1:0] l);
        int s = 0;
        for (int i = 0; i < LS; i++) s += int'(l[i]);
        return s;
    endfunction

    // Leaves the bench at posedge+1 with the DUT out of reset and idle.
    task automatic do_reset();
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        pix_in     = '0;
        line_ready = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b0;
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic send_pixel(input int v, input logic last);
        int budget = 0;
        pix_in    = PS'(v);
        pix_last  = last;
        pix_valid = 1'b1;
        while (!pix_ready && budget < 50) begin
            @(posedge CLK); #1;
            budget++;
        end
        if (!pix_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: pix_ready=%0b after %0d cycles, required 1", pix_ready, budget);
        end else begin
            @(posedge CLK); #1;
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic pulse_line_ready();
        line_ready = 1'b1;
        @(posedge CLK); #1;
        line_ready = 1'b0;
    endtask

    task automatic test_reset();
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        pix_in     = '0;
        line_ready = 1'b0;
        RST_N      = 1'b0;
        #3;
        tests_run++;
        if (pix_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_pix_ready: got %0b want 1", pix_ready); end
        tests_run++;
        if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_line_valid: got %0b want 0", line_valid); end
        tests_run++;
        if (line_len !== '0) begin tests_failed++; $display("FAIL rst_line_len: got %0d want 0", line_len); end
        tests_run++;
        if (line_out !== '0) begin tests_failed++; $display("FAIL rst_line_out: got %h want 0", line_out); end
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        tests_run++;
        if (pix_ready !== 1'b1 || line_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_rst_idle: pix_ready=%0b line_valid=%0b want 1/0", pix_ready, line_valid);
        end
    endtask

    task automatic test_full_line();
        do_reset();
        line_ready = 1'b1;
        for (int k = 0; k < LS - 1; k++) send_pixel(k + 1, 1'b0);
        tests_run++;
        if (line_valid !== 1'b0) begin tests_failed++; $display("FAIL full_early_valid: got %0b want 0", line_valid); end
        send_pixel(LS, 1'b0);
        for (int i = 0; i < LS; i++) exp_line[i] = elem(i + 1);
`ifdef PIX_SQUARE_EN
        exp_sum = 1496;
`else
        exp_sum = 136;
`endif
        tests_run++;
        if (line_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid: got %0b want 1", line_valid); end
        tests_run++;
        if (line_len !== LW'(16)) begin tests_failed++; $display("FAIL full_len: got %0d want 16", line_len); end
        tests_run++;
        if (line_out !== exp_line) begin tests_failed++; $display("FAIL full_data: got %h want %h", line_out, exp_line); end
        tests_run++;
        if (line_sum(line_out) != exp_sum) begin tests_failed++; $display("FAIL full_sum: got %0d want %0d", line_sum(line_out), exp_sum); end
        @(posedge CLK); #1;
        line_ready = 1'b0;
        tests_run++;
        if (line_valid !== 1'b0 || pix_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_consumed: line_valid=%0b pix_ready=%0b want 0/1", line_valid, pix_ready);
        end
    endtask

    task automatic test_max_pixel();
        do_reset();
        line_ready = 1'b1;
        for (int k = 0; k < LS; k++) send_pixel(255, k == LS - 1);
        for (int i = 0; i < LS; i++) exp_line[i] = elem(255);
`ifdef PIX_SQUARE_EN
        exp_sum = 1040400;
`else
        exp_sum = 4080;
`endif
        tests_run++;
        if (line_valid !== 1'b1 || line_len !== LW'(16)) begin
            tests_failed++;
            $display("FAIL max_valid_len: valid=%0b len=%0d want 1/16", line_valid, line_len);
        end
        tests_run++;
        if (line_out !== exp_line) begin tests_failed++; $display("FAIL max_data: got %h want %h", line_out, exp_line); end
        tests_run++;
        if (line_sum(line_out) != exp_sum) begin tests_failed++; $display("FAIL max_sum: got %0d want %0d", line_sum(line_out), exp_sum); end
        @(posedge CLK); #1;
        line_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [LS-1:0][PW-1:0] line1;
        logic [LS-1:0][PW-1:0] line2;
        do_reset();
        for (int i = 0; i < LS; i++) begin
            line1[i] = elem(i + 1);
            line2[i] = elem(i + 20);
        end
        for (int k = 0; k < LS; k++) send_pixel(k + 1, 1'b0);
        for (int k = 0; k < LS; k++) send_pixel(k + 20, 1'b0);
        tests_run++;
        if (pix_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %0b want 0", pix_ready); end
        tests_run++;
        if (line_valid !== 1'b1 || line_out !== line1) begin
            tests_failed++;
            $display("FAIL bp_line1: valid=%0b got %h want %h", line_valid, line_out, line1);
        end
        pix_in    = PS'(40);
        pix_last  = 1'b0;
        pix_valid = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        tests_run++;
        if (pix_ready !== 1'b0 || line_out !== line1 || line_len !== LW'(16)) begin
            tests_failed++;
            $display("FAIL bp_hold: ready=%0b len=%0d got %h want 0/16 %h", pix_ready, line_len, line_out, line1);
        end
        pulse_line_ready();
        tests_run++;
        if (pix_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_rise: got %0b want 1", pix_ready); end
        tests_run++;
        if (line_valid !== 1'b1 || line_out !== line2) begin
            tests_failed++;
            $display("FAIL bp_line2: valid=%0b got %h want %h", line_valid, line_out, line2);
        end
        for (int k = 0; k < 8; k++) send_pixel(40 + k, 1'b0);
        tests_run++;
        if (pix_ready !== 1'b1 || line_out !== line2) begin
            tests_failed++;
            $display("FAIL bp_tail: ready=%0b got %h want 1 %h", pix_ready, line_out, line2);
        end
    endtask

    task automatic test_short_line();
        do_reset();
        for (int k = 0; k < 5; k++) send_pixel(3, k == 4);
        exp_line = '0;
        for (int i = 0; i < 5; i++) exp_line[i] = elem(3);
        tests_run++;
        if (line_valid !== 1'b1 || line_len !== LW'(5)) begin
            tests_failed++;
            $display("FAIL short_len: valid=%0b len=%0d want 1/5", line_valid, line_len);
        end
        tests_run++;
        if (line_out !== exp_line) begin tests_failed++; $display("FAIL short_data: got %h want %h", line_out, exp_line); end
        send_pixel(7, 1'b0);
        send_pixel(8, 1'b1);
        tests_run++;
        if (pix_ready !== 1'b0) begin tests_failed++; $display("FAIL short_both_full: ready=%0b want 0", pix_ready); end
        pulse_line_ready();
        exp_line    = '0;
        exp_line[0] = elem(7);
        exp_line[1] = elem(8);
        tests_run++;
        if (line_valid !== 1'b1 || line_len !== LW'(2)) begin
            tests_failed++;
            $display("FAIL short2_len: valid=%0b len=%0d want 1/2", line_valid, line_len);
        end
        tests_run++;
        if (line_out !== exp_line) begin tests_failed++; $display("FAIL short2_data: got %h want %h", line_out, exp_line); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < LS; k++) send_pixel(k + 1, 1'b0);
        for (int k = 0; k < 7; k++) send_pixel(50 + k, 1'b0);
        tests_run++;
        if (line_valid !== 1'b1 || pix_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: valid=%0b ready=%0b want 1/1", line_valid, pix_ready);
        end
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (line_valid !== 1'b0 || pix_ready !== 1'b1 || line_len !== '0 || line_out !== '0) begin
            tests_failed++;
            $display("FAIL mid_async: valid=%0b ready=%0b len=%0d out=%h want 0/1/0/0", line_valid, pix_ready, line_len, line_out);
        end
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        line_ready = 1'b1;
        for (int k = 0; k < LS; k++) send_pixel(LS - k, 1'b0);
        for (int i = 0; i < LS; i++) exp_line[i] = elem(LS - i);
        tests_run++;
        if (line_valid !== 1'b1 || line_len !== LW'(16)) begin
            tests_failed++;
            $display("FAIL mid_fresh_len: valid=%0b len=%0d want 1/16", line_valid, line_len);
        end
        tests_run++;
        if (line_out !== exp_line) begin tests_failed++; $display("FAIL mid_fresh_data: got %h want %h", line_out, exp_line); end
        @(posedge CLK); #1;
        line_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_max_pixel();
        test_back_to_back();
        test_short_line();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
